// File: rtl/vga_scanout_pkg.sv
// Shared constants, handshake states and the pixel-to-address map for the frame buffer.
package vga_scanout_pkg;

  localparam int unsigned SCR_WIDTH     = 160;
  localparam int unsigned SCR_HEIGHT    = 120;
  localparam int unsigned SCALE_SHIFT   = 2;
  localparam int unsigned MEM_ADDR_BITS = 15;
  localparam int unsigned PIX_BITS      = 3;
  localparam int unsigned CNT_BITS      = 10;
  localparam int unsigned COORD_BITS    = 8;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_BUSY    = 2'd1,
    HS_RELEASE = 2'd2
  } hshake_state_e;

  // row*160 + col, built from shifts so reader and writer share one mapping.
  function automatic logic [MEM_ADDR_BITS-1:0] map_pixelco_memaddr(
    input logic [COORD_BITS-1:0] col,
    input logic [COORD_BITS-1:0] row
  );
    logic [MEM_ADDR_BITS-1:0] r;
    r = MEM_ADDR_BITS'(row);
    return (r << 7) + (r << 5) + MEM_ADDR_BITS'(col);
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Frame-buffer read port: scanout drives address/strobe, memory returns data a Clck later.
interface vga_scanout_if;
  import vga_scanout_pkg::*;

  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic                     mem_rd_en;
  logic [PIX_BITS-1:0]      mem_data;

  modport master (output mem_addr, output mem_rd_en, input mem_data);
  modport slave  (input mem_addr, input mem_rd_en, output mem_data);
endinterface

// File: rtl/vga_scanout_timing_counter.sv
// Pixel strobe, h/v raster counters and combinational region decodes.
module vga_scanout_timing_counter
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VIS = H_VISIBLE,
  parameter int unsigned H_FP  = H_FRONT,
  parameter int unsigned H_SW  = H_SYNC,
  parameter int unsigned H_BP  = H_BACK,
  parameter int unsigned V_VIS = V_VISIBLE,
  parameter int unsigned V_FP  = V_FRONT,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_BP  = V_BACK
) (
  input  logic                Clck,
  input  logic                Reset,
  output logic                pix_en,
  output logic [CNT_BITS-1:0] h_cnt,
  output logic [CNT_BITS-1:0] v_cnt,
  output logic                visible_c,
  output logic                hsync_c,
  output logic                vsync_c,
  output logic                vblank_entry_c
);

  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SW + V_BP;
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SW - 1;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SW - 1;

  logic h_last_c;
  logic v_last_c;

  assign h_last_c = (h_cnt == CNT_BITS'(H_TOTAL - 1));
  assign v_last_c = (v_cnt == CNT_BITS'(V_TOTAL - 1));

  // Strobe toggles every Clck; raster position advances only on strobe cycles.
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_last_c) begin
          h_cnt <= '0;
          v_cnt <= v_last_c ? '0 : v_cnt + CNT_BITS'(1);
        end else begin
          h_cnt <= h_cnt + CNT_BITS'(1);
        end
      end
    end
  end

  // Region decodes of the current raster position.
  always_comb begin
    visible_c      = (h_cnt < CNT_BITS'(H_VIS)) && (v_cnt < CNT_BITS'(V_VIS));
    hsync_c        = (h_cnt >= CNT_BITS'(HS_START)) && (h_cnt <= CNT_BITS'(HS_END));
    vsync_c        = (v_cnt >= CNT_BITS'(VS_START)) && (v_cnt <= CNT_BITS'(VS_END));
    vblank_entry_c = pix_en && h_last_c && (v_cnt == CNT_BITS'(V_VIS - 1));
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout of the 160x120 frame buffer with 4x4 replication and painter frame handshake.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VIS = H_VISIBLE,
  parameter int unsigned H_FP  = H_FRONT,
  parameter int unsigned H_SW  = H_SYNC,
  parameter int unsigned H_BP  = H_BACK,
  parameter int unsigned V_VIS = V_VISIBLE,
  parameter int unsigned V_FP  = V_FRONT,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_BP  = V_BACK
) (
  input  logic                Clck,
  input  logic                Reset,
  vga_scanout_if.master       mem,
  output logic [PIX_BITS-1:0] vga_rgb,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_blank_n,
  output logic                pix_en,
  output logic                paint_go,
  input  logic                paint_done,
  output logic                paint_release,
  output logic                paint_overrun
);

  logic [CNT_BITS-1:0] h_cnt;
  logic [CNT_BITS-1:0] v_cnt;
  logic                visible_c;
  logic                hsync_c;
  logic                vsync_c;
  logic                vblank_entry_c;
  logic                hs_d;
  logic                vs_d;

  hshake_state_e state_q;
  hshake_state_e state_n;
  logic          go_n;
  logic          rel_n;
  logic          ovr_n;

  vga_scanout_timing_counter #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) u_timing (
    .Clck          (Clck),
    .Reset         (Reset),
    .pix_en        (pix_en),
    .h_cnt         (h_cnt),
    .v_cnt         (v_cnt),
    .visible_c     (visible_c),
    .hsync_c       (hsync_c),
    .vsync_c       (vsync_c),
    .vblank_entry_c(vblank_entry_c)
  );

  // Address stage: issue the read for the current position, delay sync levels to match.
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      mem.mem_addr  <= '0;
      mem.mem_rd_en <= 1'b0;
      hs_d          <= 1'b1;
      vs_d          <= 1'b1;
    end else if (pix_en) begin
      if (visible_c) begin
        mem.mem_addr <= map_pixelco_memaddr(COORD_BITS'(h_cnt >> SCALE_SHIFT),
                                            COORD_BITS'(v_cnt >> SCALE_SHIFT));
      end
      mem.mem_rd_en <= visible_c;
      hs_d          <= ~hsync_c;
      vs_d          <= ~vsync_c;
    end
  end

  // Output stage: read data arrives here, rd_en doubles as the delayed visible flag.
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      vga_rgb     <= '0;
      vga_blank_n <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
    end else if (pix_en) begin
      vga_rgb     <= mem.mem_rd_en ? mem.mem_data : PIX_BITS'(0);
      vga_blank_n <= mem.mem_rd_en;
      vga_hs      <= hs_d;
      vga_vs      <= vs_d;
    end
  end

  // Handshake state and registered handshake outputs.
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      state_q       <= HS_IDLE;
      paint_go      <= 1'b0;
      paint_release <= 1'b0;
      paint_overrun <= 1'b0;
    end else begin
      state_q       <= state_n;
      paint_go      <= go_n;
      paint_release <= rel_n;
      paint_overrun <= ovr_n;
    end
  end

  // Start painter at vblank entry, release on done, flag vblanks that find it still busy.
  always_comb begin
    state_n = state_q;
    go_n    = paint_go;
    rel_n   = paint_release;
    ovr_n   = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (vblank_entry_c) begin
          go_n    = 1'b1;
          state_n = HS_BUSY;
        end
      end
      HS_BUSY: begin
        ovr_n = vblank_entry_c;
        if (paint_done) begin
          go_n    = 1'b0;
          rel_n   = 1'b1;
          state_n = HS_RELEASE;
        end
      end
      HS_RELEASE: begin
        ovr_n = vblank_entry_c;
        if (!paint_done) begin
          rel_n   = 1'b0;
          state_n = HS_IDLE;
        end
      end
      default: state_n = HS_IDLE;
    endcase
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read-side counterpart of the painter's video-memory write port.
- Generates 640x480@60 VGA timing from the 50 MHz Clck.
- Reads the 160x120 3-bit frame buffer, replicating each memory pixel 4x4 on screen, and drives RGB and sync.
- Owns the frame-level continuation handshake: starts the painter at vertical blank and releases it when it reports done.

Parameters:
- SCR_WIDTH, 160, frame-buffer width in memory pixels
- SCR_HEIGHT, 120, frame-buffer height in memory pixels
- SCALE_SHIFT, 2, log2 of screen pixels per memory pixel
- MEM_ADDR_BITS, 15, frame-buffer address width
- H_VISIBLE/H_FRONT/H_SYNC/H_BACK, 640/16/96/48, horizontal timing in pixel ticks
- V_VISIBLE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33, vertical timing in lines

Ports:
- Clck  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-low
- mem_addr  out  MEM_ADDR_BITS  frame-buffer read address
- mem_rd_en  out  1  read strobe
- mem_data  in  3  read data, valid one Clck after mem_addr/mem_rd_en
- vga_rgb  out  3  pixel colour {r,g,b}
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_blank_n  out  1  high in the visible area
- pix_en  out  1  pixel-clock strobe, one Clck in two
- paint_go  out  1  to painter in_cont_signal
- paint_done  in  1  from painter out_cont_signal
- paint_release  out  1  to painter next_out_cont_signal
- paint_overrun  out  1  one-Clck pulse: painter still busy at a new vblank

Behaviour:
- Reset (Reset==0 at a Clck edge) sets: h_cnt=0, v_cnt=0, pix_en=0, mem_addr=0, mem_rd_en=0, vga_rgb=0, vga_hs=1, vga_vs=1, vga_blank_n=0, paint_go=0, paint_release=0, paint_overrun=0, handshake state IDLE.
- Reset mid-frame restarts at (0,0) on the next cycle and aborts the handshake (go=0). The painter is not reset by this block.
- pix_en toggles every Clck. The first Clck after reset has pix_en=1.
- Timing counters advance only on pix_en cycles:
  - h_cnt 0..799, wraps to 0.
  - v_cnt increments on h wrap; v_cnt 0..524, wraps to 0.
- Address pipeline (pix_en cycle t):
  - mem_addr <= (v_cnt>>2)*160 + (h_cnt>>2), computed as (row<<7)+(row<<5)+col.
  - mem_rd_en <= visible(h,v), where visible = h<640 && v<480.
  - Outside the visible area mem_addr holds its last value.
- Output stage (pix_en cycle t+1):
  - vga_rgb <= visible_d ? mem_data : 3'b000.
  - vga_blank_n <= visible_d.
  - vga_hs <= !(656<=h_d<=751).
  - vga_vs <= !(490<=v_d<=491).
  - All VGA outputs lag the counters by exactly one pixel tick and stay mutually aligned.
- Handshake FSM (evaluated every Clck):
  - IDLE: on the pix_en cycle where counters become (h=0, v=480), set paint_go=1 and go to BUSY.
  - BUSY: when paint_done==1, paint_go=0 and paint_release=1 on the next edge; go to RELEASE.
  - RELEASE: hold paint_release=1 until paint_done==0, then paint_release=0; go to IDLE.
  - Vblank entry while in BUSY or RELEASE: pulse paint_overrun for one Clck, no restart, paint_go unchanged.
  - paint_done==1 while in IDLE is ignored.
- Tearing while painting overlaps scanout is tolerated; no double buffering.

Decomposition:
- header.v additions: VGA timing constants, SCALE_SHIFT, MEM_ADDR_BITS.
- Reuse the existing SCR_WIDTH/SCR_HEIGHT and MAP_PIXELCO_MEMADDR so reader and writer addressing are identical.
- Sub-module vga_timing_counter: pix_en, h_cnt, v_cnt, visible, hs/vs decode.
- The top level holds the address pipeline and the handshake FSM.

Test Plan:
- Timing after reset:
  - vga_hs low for exactly 96 pixel ticks starting 656+1 ticks after line start.
  - Line = 1600 Clck.
  - vga_vs low for 2 lines.
  - Frame = 840000 Clck.
- Address map:
  - Counters (0,0) -> mem_addr 0.
  - Counters (639,479) -> 19199.
  - Counters (4,4) -> 161.
  - mem_rd_en=0 at h=640.
- Replication: preload addr 0 = 3'b110, addr 1 = 3'b001. First visible line shows 110 for 4 pixels, then 001; lines 0..3 are identical.
- Blanking: memory all 3'b111. vga_rgb = 0 and vga_blank_n = 0 throughout h 640..799 and v 480..524.
- Handshake:
  - paint_go rises at vblank entry.
  - Bench raises paint_done 100 Clck later: paint_go falls next Clck and paint_release=1.
  - Bench drops paint_done: paint_release falls next Clck.
- Overrun and reset:
  - Hold paint_done=0 across two vblanks: one paint_overrun pulse at the second, paint_go stays 1.
  - Reset=0 at v=200: all outputs return to reset values next Clck and paint_go=0.
